// File: rtl/pwm_led_pkg.sv
// rtl/pwm_led_pkg.sv - shared encodings for the multi-channel PWM LED driver
package pwm_led_pkg;

  localparam int CMD_INC_C = 4;
  localparam int CMD_DEC_C = 3;
  localparam int CMD_INC_1 = 2;
  localparam int CMD_DEC_1 = 1;
  localparam int CMD_HALF  = 0;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_BREATH = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_INC_C,
    OP_DEC_C,
    OP_INC_1,
    OP_DEC_1,
    OP_HALF
  } op_e;

  // Highest bit wins when several command edges coincide.
  function automatic op_e decode_op(input logic [4:0] edges);
    op_e op;
    op = OP_NONE;
    if (edges[CMD_INC_C])      op = OP_INC_C;
    else if (edges[CMD_DEC_C]) op = OP_DEC_C;
    else if (edges[CMD_INC_1]) op = OP_INC_1;
    else if (edges[CMD_DEC_1]) op = OP_DEC_1;
    else if (edges[CMD_HALF])  op = OP_HALF;
    return op;
  endfunction

endpackage

// File: rtl/pwm_led_chan.sv
// rtl/pwm_led_chan.sv - one PWM channel: saturating target, period-synchronous active duty,
// triangle breathing and registered comparator
module pwm_led_chan
  import pwm_led_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COARSE_STEP = 10,
  parameter int BREATH_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] phase,
  input  logic             period_end,
  input  logic             sel,
  input  op_e              op,
  input  logic             toggle,
  output logic             led
);

  localparam logic [WIDTH:0] MAX   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] CSTEP = (WIDTH + 1)'(COARSE_STEP);
  localparam logic [WIDTH:0] BSTEP = (WIDTH + 1)'(BREATH_STEP);

  logic [WIDTH-1:0] target, target_nxt;
  logic [WIDTH-1:0] active, active_nxt;
  logic             mode, dir, dir_nxt;
  logic [WIDTH:0]   t_ext, a_ext;

  always_comb begin
    t_ext      = {1'b0, target};
    a_ext      = {1'b0, active};
    target_nxt = target;
    active_nxt = active;
    dir_nxt    = dir;

    if (sel) begin
      case (op)
        OP_INC_C: target_nxt = (t_ext + CSTEP > MAX) ? '1 : WIDTH'(t_ext + CSTEP);
        OP_DEC_C: target_nxt = (t_ext < CSTEP) ? '0 : WIDTH'(t_ext - CSTEP);
        OP_INC_1: target_nxt = (target == '1) ? target : target + 1'b1;
        OP_DEC_1: target_nxt = (target == '0) ? target : target - 1'b1;
        OP_HALF:  target_nxt = WIDTH'(MAX >> 1);
        default:  target_nxt = target;
      endcase
    end

    // Period-end uses the registered (pre-command, pre-toggle) target and mode.
    if (period_end) begin
      if (mode == MODE_STATIC) begin
        active_nxt = target;
      end else if (dir == DIR_UP) begin
        if (a_ext + BSTEP >= MAX) begin
          active_nxt = '1;
          dir_nxt    = DIR_DOWN;
        end else begin
          active_nxt = WIDTH'(a_ext + BSTEP);
        end
      end else begin
        if (a_ext <= BSTEP) begin
          active_nxt = '0;
          dir_nxt    = DIR_UP;
        end else begin
          active_nxt = WIDTH'(a_ext - BSTEP);
        end
      end
    end

    if (toggle && sel && mode == MODE_STATIC) dir_nxt = DIR_UP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target <= '0;
      active <= '0;
      mode   <= MODE_STATIC;
      dir    <= DIR_UP;
      led    <= 1'b0;
    end else begin
      target <= target_nxt;
      active <= active_nxt;
      dir    <= dir_nxt;
      if (toggle && sel) mode <= ~mode;
      led    <= (phase < active);
    end
  end

endmodule

// File: rtl/pwm_led_multi.sv
// rtl/pwm_led_multi.sv - multi-channel PWM LED driver: prescaler, phase counter,
// command edge detect and channel decode
module pwm_led_multi
  import pwm_led_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int PRESCALE    = 196,
  parameter int COARSE_STEP = 10,
  parameter int BREATH_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          cmd,
  input  logic                mode_toggle,
  input  logic [3:0]          ch_sel,
  output logic [CHANNELS-1:0] led,
  output logic                period_start
);

  localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;
  logic [WIDTH-1:0] phase;
  logic [4:0]       cmd_q;
  logic             tog_q;
  logic             tick, period_end, tog_edge;
  op_e              op;

  assign tick       = (pre == PRE_LAST);
  assign period_end = tick && (phase == '1);
  assign tog_edge   = mode_toggle & ~tog_q;
  assign op         = decode_op(cmd & ~cmd_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre          <= '0;
      phase        <= '0;
      cmd_q        <= '0;
      tog_q        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pre          <= tick ? '0 : pre + 1'b1;
      if (tick) phase <= phase + 1'b1;
      cmd_q        <= cmd;
      tog_q        <= mode_toggle;
      period_start <= period_end;
    end
  end

  // ch_sel values at or above CHANNELS match no instance, so they are ignored.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_led_chan #(
      .WIDTH      (WIDTH),
      .COARSE_STEP(COARSE_STEP),
      .BREATH_STEP(BREATH_STEP)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .phase     (phase),
      .period_end(period_end),
      .sel       (ch_sel == 4'(i)),
      .op        (op),
      .toggle    (tog_edge),
      .led       (led[i])
    );
  end

endmodule

// File: tb/tb_pwm_led_multi.sv
// tb/tb_pwm_led_multi.sv - self-checking bench for pwm_led_multi
module tb_pwm_led_multi;

  localparam int CH = 4, W = 4, PS = 2, CS = 3, BS = 5;
  localparam int MAXV = 15, PER = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    cmd = '0;
  logic          mode_toggle = 1'b0;
  logic [3:0]    ch_sel = '0;
  logic [CH-1:0] led;
  logic          period_start;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_led_multi #(
    .CHANNELS(CH), .WIDTH(W), .PRESCALE(PS), .COARSE_STEP(CS), .BREATH_STEP(BS)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .mode_toggle(mode_toggle), .ch_sel(ch_sel),
    .led(led), .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Reference model: phase and period boundaries derive from a cycle count since reset.
  int            cyc;
  int            m_tgt[CH], m_act[CH];
  bit            m_breath[CH], m_down[CH];
  logic [4:0]    m_cmd_prev, m_e;
  logic          m_tog_prev;
  logic [CH-1:0] m_led;
  logic          m_ps;
  int            m_ph, m_s;
  bit            m_pe;

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0; m_cmd_prev = '0; m_tog_prev = 1'b0; m_led = '0; m_ps = 1'b0;
      for (int i = 0; i < CH; i++) begin
        m_tgt[i] = 0; m_act[i] = 0; m_breath[i] = 0; m_down[i] = 0;
      end
    end else begin
      m_ph = (cyc / PS) % (MAXV + 1);
      m_pe = (cyc % PER) == PER - 1;
      m_e  = cmd & ~m_cmd_prev;
      for (int i = 0; i < CH; i++) m_led[i] = (m_ph < m_act[i]);
      m_ps = m_pe;
      if (m_pe) begin
        for (int i = 0; i < CH; i++) begin
          if (!m_breath[i]) m_act[i] = m_tgt[i];
          else if (!m_down[i]) begin
            if (m_act[i] + BS >= MAXV) begin m_act[i] = MAXV; m_down[i] = 1; end
            else m_act[i] = m_act[i] + BS;
          end else begin
            if (m_act[i] <= BS) begin m_act[i] = 0; m_down[i] = 0; end
            else m_act[i] = m_act[i] - BS;
          end
        end
      end
      if (int'(ch_sel) < CH) begin
        m_s = int'(ch_sel);
        if (m_e[4])      m_tgt[m_s] = (m_tgt[m_s] + CS > MAXV) ? MAXV : m_tgt[m_s] + CS;
        else if (m_e[3]) m_tgt[m_s] = (m_tgt[m_s] < CS) ? 0 : m_tgt[m_s] - CS;
        else if (m_e[2]) m_tgt[m_s] = (m_tgt[m_s] == MAXV) ? MAXV : m_tgt[m_s] + 1;
        else if (m_e[1]) m_tgt[m_s] = (m_tgt[m_s] == 0) ? 0 : m_tgt[m_s] - 1;
        else if (m_e[0]) m_tgt[m_s] = MAXV / 2;
        if (mode_toggle && !m_tog_prev) begin
          m_breath[m_s] = !m_breath[m_s];
          if (m_breath[m_s]) m_down[m_s] = 0;
        end
      end
      m_cmd_prev = cmd; m_tog_prev = mode_toggle;
      cyc++;
    end
  end

  task automatic press(input logic [4:0] bits);
    @(negedge clk); cmd = bits;
    @(negedge clk); cmd = '0;
  endtask

  task automatic pulse_toggle();
    @(negedge clk); mode_toggle = 1'b1;
    @(negedge clk); mode_toggle = 1'b0;
  endtask

  // Leaves the bench at the negedge just before the posedge whose cycle index mod PER is pos.
  task automatic align(input int pos, output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      if (cyc % PER == pos) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    int pulses, last;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (led !== '0 || period_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_out led=%b ps=%b required led=0 ps=0", led, period_start);
    end
    rst = 1'b0;
    pulses = 0; last = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_checks++;
      if (led !== m_led || period_start !== m_ps) begin
        n_fail++; $display("FAIL idle_out k=%0d led=%b ps=%b required led=%b ps=%b", k, led, period_start, m_led, m_ps);
      end
      if (period_start === 1'b1) begin
        if (last >= 0) begin
          n_checks++;
          if (k - last != PER) begin n_fail++; $display("FAIL ps_spacing got=%0d required=%0d", k - last, PER); end
        end
        last = k; pulses++;
      end
    end
    n_checks++;
    if (pulses != 3) begin n_fail++; $display("FAIL ps_count got=%0d required=3", pulses); end
  endtask

  task automatic test_hold();
    int highs;
    ch_sel = 4'd1;
    repeat (3) press(5'b00100);
    @(negedge clk); cmd = 5'b00100;
    repeat (20) @(negedge clk);
    cmd = '0;
    n_checks++;
    if (dut.g_chan[1].u_chan.target !== 4'd4) begin
      n_fail++; $display("FAIL hold_target got=%0d required=4", dut.g_chan[1].u_chan.target);
    end
    highs = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      n_checks++;
      if (led !== m_led || period_start !== m_ps) begin
        n_fail++; $display("FAIL hold_out k=%0d led=%b ps=%b required led=%b ps=%b", k, led, period_start, m_led, m_ps);
      end
      if (k >= 38 && led[1] === 1'b1) highs++;
    end
    n_checks++;
    if (highs != 8) begin n_fail++; $display("FAIL hold_duty got=%0d required=8", highs); end
  endtask

  task automatic test_saturate();
    int exp_t[14] = '{3, 6, 9, 12, 15, 15, 12, 9, 6, 3, 0, 0, 7, 10};
    logic [4:0] seq[14];
    for (int i = 0; i < 6; i++) begin seq[i] = 5'b10000; seq[i + 6] = 5'b01000; end
    seq[12] = 5'b00001;
    seq[13] = 5'b10010;
    ch_sel = 4'd0;
    for (int i = 0; i < 14; i++) begin
      press(seq[i]);
      n_checks++;
      if (dut.g_chan[0].u_chan.target !== 4'(exp_t[i]) || m_tgt[0] != exp_t[i]) begin
        n_fail++; $display("FAIL sat_target step=%0d got=%0d required=%0d", i, dut.g_chan[0].u_chan.target, exp_t[i]);
      end
    end
  endtask

  task automatic test_boundary();
    bit ok;
    int first, second;
    ch_sel = 4'd3;
    align(PER - 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bnd_align got=timeout required=aligned"); end
    cmd = 5'b00001;
    @(negedge clk); cmd = '0;
    first = 0; second = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      n_checks++;
      if (led !== m_led || period_start !== m_ps) begin
        n_fail++; $display("FAIL bnd_out k=%0d led=%b ps=%b required led=%b ps=%b", k, led, period_start, m_led, m_ps);
      end
      if (led[3] === 1'b1) begin
        if (k <= 32) first++; else second++;
      end
    end
    n_checks++;
    if (first != 0) begin n_fail++; $display("FAIL bnd_old_period got=%0d required=0", first); end
    n_checks++;
    if (second != 14) begin n_fail++; $display("FAIL bnd_new_period got=%0d required=14", second); end
  endtask

  task automatic test_breath();
    int exp_a[7] = '{5, 10, 15, 10, 5, 0, 5};
    bit ok;
    ch_sel = 4'd2;
    align(5, ok);
    pulse_toggle();
    for (int i = 0; i < 7; i++) begin
      align(0, ok);
      n_checks++;
      if (!ok || dut.g_chan[2].u_chan.active !== 4'(exp_a[i])) begin
        n_fail++; $display("FAIL breath_active idx=%0d got=%0d required=%0d", i, dut.g_chan[2].u_chan.active, exp_a[i]);
      end
      n_checks++;
      if (led !== m_led) begin n_fail++; $display("FAIL breath_out idx=%0d led=%b required=%b", i, led, m_led); end
    end
    press(5'b00001);
    align(5, ok);
    pulse_toggle();
    align(0, ok);
    n_checks++;
    if (!ok || dut.g_chan[2].u_chan.active !== 4'd7) begin
      n_fail++; $display("FAIL breath_exit got=%0d required=7", dut.g_chan[2].u_chan.active);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ch_sel = 4'd3;
    press(5'b00100);
    press(5'b00100);
    pulse_toggle();
    n_checks++;
    if (dut.g_chan[3].u_chan.target !== 4'd9) begin
      n_fail++; $display("FAIL rmid_target got=%0d required=9", dut.g_chan[3].u_chan.target);
    end
    align(16, ok);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (led !== '0 || period_start !== 1'b0 || dut.phase !== '0) begin
      n_fail++; $display("FAIL rmid_out led=%b ps=%b phase=%0d required 0 0 0", led, period_start, dut.phase);
    end
    n_checks++;
    if (dut.g_chan[3].u_chan.mode !== 1'b0 || dut.g_chan[3].u_chan.active !== 4'd0) begin
      n_fail++; $display("FAIL rmid_chan mode=%b active=%0d required mode=0 active=0",
                         dut.g_chan[3].u_chan.mode, dut.g_chan[3].u_chan.active);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_checks++;
      if (led !== m_led || period_start !== m_ps) begin
        n_fail++; $display("FAIL rmid_after k=%0d led=%b ps=%b required led=%b ps=%b", k, led, period_start, m_led, m_ps);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      n_checks++;
      if (led !== m_led || period_start !== m_ps) begin
        n_fail++; $display("FAIL rand_out k=%0d led=%b ps=%b required led=%b ps=%b", k, led, period_start, m_led, m_ps);
      end
      ch_sel      = 4'($urandom_range(0, 7));
      cmd         = 5'($urandom & $urandom & $urandom);
      mode_toggle = ($urandom_range(0, 15) == 0);
    end
    cmd = '0; mode_toggle = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut.g_chan[0].u_chan.target !== 4'(m_tgt[0]) || dut.g_chan[1].u_chan.target !== 4'(m_tgt[1]) ||
        dut.g_chan[2].u_chan.target !== 4'(m_tgt[2]) || dut.g_chan[3].u_chan.target !== 4'(m_tgt[3])) begin
      n_fail++; $display("FAIL rand_targets got=%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d",
                         dut.g_chan[0].u_chan.target, dut.g_chan[1].u_chan.target,
                         dut.g_chan[2].u_chan.target, dut.g_chan[3].u_chan.target,
                         m_tgt[0], m_tgt[1], m_tgt[2], m_tgt[3]);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_saturate();
    test_boundary();
    test_breath();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired required=finish");
    $fatal(1);
  end

endmodule
